food_spawner: RTL and testbench

//  Producer side of the game core's food handshake. Watches food_valid_1/2 from the

---
 rtl/food_spawner.sv | 180 ++++++++++++++++++
 tb/tb_food_spawner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_spawner.sv
// food_spawner: producer side of the game core's food handshake.
// Two channels watch food_valid_1/2; when a channel reports no food it draws
// pseudo-random in-grid coordinates from one shared 16-bit LFSR, registers
// them and pulses food_received for one cycle.
// Optional feature macro: FOOD_AVOID_DUP_EN (reject a candidate equal to the
// other channel's current food; the fallback nudges x by one on collision).

module food_spawner #(
    parameter int unsigned GRID_W    = 160,
    parameter int unsigned GRID_H    = 120,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go_signal,
    input  logic       food_valid_1,
    input  logic       food_valid_2,
    output logic [7:0] new_food_x1,
    output logic [6:0] new_food_y1,
    output logic [7:0] new_food_x2,
    output logic [6:0] new_food_y2,
    output logic       food_received_1,
    output logic       food_received_2
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [8:0] GW      = 9'(GRID_W);
    localparam logic [7:0] GH      = 8'(GRID_H);
    localparam logic [3:0] TRY_MAX = 4'(MAX_TRIES);
    localparam logic [7:0] X1_RST  = 8'(GRID_W / 4);
    localparam logic [7:0] X2_RST  = 8'(3 * GRID_W / 4);
    localparam logic [6:0] Y_RST   = 7'(GRID_H / 2);

    logic [15:0]     lfsr;
    logic [7:0]      cx;
    logic [6:0]      cy;
    logic            in_grid;
    logic [7:0]      fb_x0;
    logic [6:0]      fb_y0;
    logic [1:0][7:0] x_all;
    logic [1:0][6:0] y_all;
    logic [1:0]      gen_all;
    logic [1:0]      recv_all;

    // Free-running Fibonacci LFSR shared by both channels
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cx = lfsr[15:8];
    assign cy = lfsr[6:0];

    // Candidate range test and single-subtraction fallback fold
    always_comb begin
        in_grid = ({1'b0, cx} < GW) && ({1'b0, cy} < GH);
        fb_x0   = ({1'b0, cx} >= GW) ? 8'({1'b0, cx} - GW) : cx;
        fb_y0   = ({1'b0, cy} >= GH) ? 7'({1'b0, cy} - GH) : cy;
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int unsigned O      = 1 - g;
        localparam logic [7:0]  X_RST  = (g == 0) ? X1_RST : X2_RST;

        logic [1:0] state_q, state_d;
        logic [3:0] try_q, try_d;
        logic [7:0] x_q, x_d;
        logic [6:0] y_q, y_d;
        logic       recv_q;
        logic       fv;
        logic       grant;
        logic       cand_ok;
        logic [7:0] fb_x;
        logic [6:0] fb_y;
        logic       eval;
        logic       fallback;
        logic       accept;

        assign fv    = (g == 0) ? food_valid_1 : food_valid_2;
        // Channel 1 always wins when both are generating
        assign grant = (g == 0) ? 1'b1 : !gen_all[0];

`ifdef FOOD_AVOID_DUP_EN
        logic fb_dup;

        // Reject duplicates of the other channel's food; nudge the fallback x
        always_comb begin
            cand_ok = in_grid && !((cx == x_all[O]) && (cy == y_all[O]));
            fb_dup  = (fb_x0 == x_all[O]) && (fb_y0 == y_all[O]);
            fb_y    = fb_y0;
            if (fb_dup) begin
                fb_x = ({1'b0, fb_x0} == GW - 9'd1) ? 8'd0 : fb_x0 + 8'd1;
            end else begin
                fb_x = fb_x0;
            end
        end
`else
        // No duplicate check: both foods may coincide
        always_comb begin
            cand_ok = in_grid;
            fb_x    = fb_x0;
            fb_y    = fb_y0;
        end
`endif

        assign eval     = (state_q == ST_GEN) && go_signal && grant;
        assign fallback = (try_q >= TRY_MAX);
        assign accept   = eval && (cand_ok || fallback);

        // Channel FSM next-state, try counter and coordinate capture
        always_comb begin
            state_d = state_q;
            try_d   = try_q;
            x_d     = x_q;
            y_d     = y_q;
            case (state_q)
                ST_IDLE: begin
                    if (!fv) begin
                        state_d = ST_GEN;
                        try_d   = 4'd0;
                    end
                end
                ST_GEN: begin
                    if (accept) begin
                        state_d = ST_ACK;
                        x_d     = cand_ok ? cx : fb_x;
                        y_d     = cand_ok ? cy : fb_y;
                    end else if (eval) begin
                        try_d = try_q + 4'd1;
                    end
                end
                ST_ACK:  state_d = ST_WAIT;
                ST_WAIT: begin
                    if (fv) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Channel state registers; the pulse is high for the whole ACK cycle
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= ST_IDLE;
                try_q   <= 4'd0;
                x_q     <= X_RST;
                y_q     <= Y_RST;
                recv_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                try_q   <= try_d;
                x_q     <= x_d;
                y_q     <= y_d;
                recv_q  <= accept;
            end
        end

        assign x_all[g]    = x_q;
        assign y_all[g]    = y_q;
        assign gen_all[g]  = (state_q == ST_GEN);
        assign recv_all[g] = recv_q;
    end

    assign new_food_x1     = x_all[0];
    assign new_food_y1     = y_all[0];
    assign new_food_x2     = x_all[1];
    assign new_food_y2     = y_all[1];
    assign food_received_1 = recv_all[0];
    assign food_received_2 = recv_all[1];

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: stimulus pushes expected pulses (cycle
// window plus exact or in-grid coordinates) and a negedge monitor pops and
// compares whenever a food_received pulse appears.

module tb_food_spawner;

    logic clk = 1'b0;
    logic resetn;
    logic go;
    logic a_fv1, a_fv2, b_fv1, b_fv2;
    logic [7:0] a_x1, a_x2, b_x1, b_x2;
    logic [6:0] a_y1, a_y2, b_y1, b_y2;
    logic a_rcv1, a_rcv2, b_rcv1, b_rcv2;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        int lo;
        int hi;
        bit exact;
        int x;
        int y;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    bit    prev[4];
    int    pulses[4];
    int    last[4];
    string nm[4] = '{"a1", "a2", "b1", "b2"};

    always #5 clk = ~clk;

    // Default parameters, seed 16'hACE1
    food_spawner dut_a (
        .clk             (clk),
        .resetn          (resetn),
        .go_signal       (go),
        .food_valid_1    (a_fv1),
        .food_valid_2    (a_fv2),
        .new_food_x1     (a_x1),
        .new_food_y1     (a_y1),
        .new_food_x2     (a_x2),
        .new_food_y2     (a_y2),
        .food_received_1 (a_rcv1),
        .food_received_2 (a_rcv2)
    );

    // MAX_TRIES=0; seed steps to 16'hC87D (cx=200, cy=125) on the first edge
    food_spawner #(
        .LFSR_SEED (16'hE43E),
        .MAX_TRIES (0)
    ) dut_b (
        .clk             (clk),
        .resetn          (resetn),
        .go_signal       (go),
        .food_valid_1    (b_fv1),
        .food_valid_2    (b_fv2),
        .new_food_x1     (b_x1),
        .new_food_y1     (b_y1),
        .new_food_x2     (b_x2),
        .new_food_y2     (b_y2),
        .food_received_1 (b_rcv1),
        .food_received_2 (b_rcv2)
    );

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic int qtot();
        return q0.size() + q1.size() + q2.size() + q3.size();
    endfunction

    function automatic exp_t mk(input int lo, input int hi, input bit exact,
                                input int x, input int y);
        exp_t e;
        e.lo = lo; e.hi = hi; e.exact = exact; e.x = x; e.y = y;
        return e;
    endfunction

    task automatic mon(input int id, input logic rcv, input logic [7:0] x, input logic [6:0] y);
        exp_t e;
        bit   have;
        if (!rcv) begin
            prev[id] = 1'b0;
        end else begin
            chk($sformatf("%s_pulse_width", nm[id]), int'(prev[id]), 0);
            prev[id] = 1'b1;
            pulses[id]++;
            last[id] = cyc;
            have = 1'b0;
            case (id)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                chk($sformatf("%s_unexpected_pulse", nm[id]), 1, 0);
            end else begin
                chk_range($sformatf("%s_cycle", nm[id]), cyc, e.lo, e.hi);
                if (e.exact) begin
                    chk($sformatf("%s_x", nm[id]), int'(x), e.x);
                    chk($sformatf("%s_y", nm[id]), int'(y), e.y);
                end else begin
                    chk_range($sformatf("%s_x", nm[id]), int'(x), 0, 159);
                    chk_range($sformatf("%s_y", nm[id]), int'(y), 0, 119);
                end
            end
        end
    endtask

    // Monitor: compares every presented pulse against the scoreboard
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) prev[i] = 1'b0;
        end else begin
            mon(0, a_rcv1, a_x1, a_y1);
            mon(1, a_rcv2, a_x2, a_y2);
            mon(2, b_rcv1, b_x1, b_y1);
            mon(3, b_rcv2, b_x2, b_y2);
            if (a_rcv1 || a_rcv2) chk("a_same_cycle", int'(a_rcv1 && a_rcv2), 0);
            if (b_rcv1 || b_rcv2) chk("b_same_cycle", int'(b_rcv1 && b_rcv2), 0);
`ifdef FOOD_AVOID_DUP_EN
            if (a_rcv2) chk("a_dup", int'({a_x2, a_y2} == {a_x1, a_y1}), 0);
            if (b_rcv2) chk("b_dup", int'({b_x2, b_y2} == {b_x1, b_y1}), 0);
`endif
        end
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (qtot() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, qtot(), 0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic chk_reset_coords(input string tag);
        chk({tag, "_x1"}, int'(a_x1), 40);
        chk({tag, "_y1"}, int'(a_y1), 60);
        chk({tag, "_x2"}, int'(a_x2), 120);
        chk({tag, "_y2"}, int'(a_y2), 60);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int m;
        int p0;
        int n;
        logic [7:0] xh;
        logic [6:0] yh;

        for (int i = 0; i < 4; i++) begin
            prev[i] = 1'b0; pulses[i] = 0; last[i] = 0;
        end
        resetn = 1'b0;
        go     = 1'b1;
        a_fv1  = 1'b0;
        a_fv2  = 1'b1;
        b_fv1  = 1'b0;
        b_fv2  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk_reset_coords("rst");
        chk("rst_rcv1", int'(a_rcv1), 0);
        chk("rst_rcv2", int'(a_rcv2), 0);
        chk("rst_b_x2", int'(b_x2), 120);

        // Pending needs from reset: dut_a ch1 draws 16'h59C3 -> (89,67);
        // dut_b ch1 folds (200,125) -> (40,5); dut_b ch2 loses edge 2 to
        // ch1, then folds 16'h90FB (144,123) -> (144,3)
        q0.push_back(mk(2, 2, 1'b1, 89, 67));
        q2.push_back(mk(2, 2, 1'b1, 40, 5));
        q3.push_back(mk(3, 3, 1'b1, 144, 3));
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("lfsr_first_edge", int'(dut_a.lfsr), 16'h59C3);
        drain("drain_initial", 10);
        chk("a_ch2_untouched_x", int'(a_x2), 120);
        chk("a_ch2_untouched_y", int'(a_y2), 60);
        @(negedge clk);
        a_fv1 = 1'b1; b_fv1 = 1'b1; b_fv2 = 1'b1;
        repeat (3) @(negedge clk);

        // Single channel request with go high
        k = cyc;
        a_fv1 = 1'b0;
        q0.push_back(mk(k + 2, k + 10, 1'b0, 0, 0));
        drain("drain_single", 30);
        @(negedge clk);
        a_fv1 = 1'b1;
        xh = a_x1; yh = a_y1;
        repeat (5) @(negedge clk);
        chk("hold_x1", int'(a_x1), int'(xh));
        chk("hold_y1", int'(a_y1), int'(yh));
        chk("single_ch2_x", int'(a_x2), 120);
        chk("single_ch2_y", int'(a_y2), 60);

        // go low throughout GEN: no pulse, then pulse soon after go rises
        go = 1'b0;
        a_fv1 = 1'b0;
        p0 = pulses[0];
        repeat (50) @(negedge clk);
        chk("go_low_no_pulse", pulses[0] - p0, 0);
        m = cyc;
        go = 1'b1;
        q0.push_back(mk(m + 1, m + 9, 1'b0, 0, 0));
        drain("drain_go", 20);
        @(negedge clk);
        a_fv1 = 1'b1;
        repeat (3) @(negedge clk);

        // Both channels request together: channel 1 strictly first
        k = cyc;
        a_fv1 = 1'b0;
        a_fv2 = 1'b0;
        q0.push_back(mk(k + 2, k + 10, 1'b0, 0, 0));
        q1.push_back(mk(k + 3, k + 20, 1'b0, 0, 0));
        drain("drain_both", 40);
        chk("ch1_before_ch2", int'(last[0] < last[1]), 1);
        @(negedge clk);
        a_fv1 = 1'b1;
        a_fv2 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset asserted during ACK
        k = cyc;
        a_fv1 = 1'b0;
        q0.push_back(mk(k + 2, k + 10, 1'b0, 0, 0));
        n = 0;
        while (!a_rcv1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_reached", int'(a_rcv1), 1);
        #1;
        a_fv1 = 1'b1;
        resetn = 1'b0;
        #1;
        chk("rst_in_ack_rcv1", int'(a_rcv1), 0);
        chk_reset_coords("rst_in_ack");
        q0.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_coords("post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
